sobel_window_ctrl: RTL and testbench
====================================

SOBEL_WINDOW_CTRL -- requirements
Module: sobel_window_ctrl

Interface
REQ-001 Parameter IMG_W, default 64: image width in pixels; legal range 3..4096.
REQ-002 Parameter IMG_H, default 64: image height in pixels; legal range 3..4096.
REQ-003 Parameter AW, default 12: memory address width; IMG_W*IMG_H SHALL be <= 2^AW.
REQ-004 Port clk, input, 1: single clock; all state SHALL change on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port start_i, input, 1: begin one frame pass; sampled only in IDLE.
REQ-007 Port hold_i, input, 1: while high, the block SHALL issue no new memory read.
REQ-008 Port mem_rd_en_o, output, 1: one-cycle memory read strobe.
REQ-009 Port mem_addr_o, output, AW: read address; valid while mem_rd_en_o is high.
REQ-010 Port mem_rdata_i, input, 8: read data, valid exactly one cycle after mem_rd_en_o.
REQ-011 Port win_o, output, 72: 3x3 window; byte k=r*3+c at bits [8k+7:8k]; r=0 is the top row, c=0 is the left column.
REQ-012 Port core_en_o, output, 1: one-cycle strobe marking a new complete window on win_o.
REQ-013 Port ctr_x_o, output, 12: window-centre column, valid with core_en_o.
REQ-014 Port ctr_y_o, output, 12: window-centre row, valid with core_en_o.
REQ-015 Port busy_o, output, 1: high from the cycle after start is accepted until done_o.
REQ-016 Port done_o, output, 1: one-cycle end-of-frame pulse.

Function
REQ-017 States: IDLE, RUN, FIN. Transitions: IDLE->RUN when start_i=1; RUN->FIN after the last read is issued; FIN->IDLE in the cycle done_o pulses.
REQ-018 Processing order: for each centre row y=1..IMG_H-2, for each column c=0..IMG_W-1, the block SHALL issue three reads in consecutive un-held cycles, in the order row y-1, row y, row y+1.
REQ-019 Addressing: each read address SHALL equal row*IMG_W+c, computed without a multiplier.
REQ-020 Column shift: when the row y+1 byte of a column returns, window columns SHALL shift left (c0<=c1, c1<=c2, c2<=new column) in the same edge.
REQ-021 Window emission: once at least 3 columns of the current row have been shifted in, core_en_o SHALL pulse in the cycle after each shift, with ctr_x_o=c-1 and ctr_y_o=y.
REQ-022 Row boundaries: the column count SHALL reset at each new row so that no window mixes two rows; reads of the next row SHALL follow the previous row's last read with no gap; each row SHALL produce IMG_W-2 windows.
REQ-023 Hold: the read sequence SHALL freeze while hold_i is high, but data for an already-issued read SHALL still be captured.
REQ-024 Start handling: start_i SHALL be ignored outside IDLE; start is accepted even when hold_i is high, with reads deferred until hold_i falls.
REQ-025 Frame end: done_o SHALL pulse one cycle after the final core_en_o, and busy_o SHALL be low from that same cycle.
REQ-026 Throughput: one window per 3 cycles in steady state with no hold.
REQ-027 Latency: with no hold, the first read SHALL occur 1 cycle after start is accepted and the first core_en_o 11 cycles after it.

Reset
REQ-028 On rst_n low the block SHALL asynchronously enter IDLE, and all outputs, win_o and all counters SHALL be 0.
REQ-029 Reset during RUN or FIN SHALL abort the frame with no done_o pulse; a new start_i is required afterwards.

Configuration
REQ-030 Macro SOBEL_CTRL_PERF_EN defined: the block SHALL add output perf_hold_cnt_o [31:0], which counts cycles where busy_o=1 and hold_i=1, clears on start acceptance, and saturates at all-ones.
REQ-031 Macro SOBEL_CTRL_PERF_EN undefined: the port and its counter SHALL NOT exist; all other behaviour SHALL be identical.

Verification
All scenarios use IMG_W=4, IMG_H=4, mem[a]=a, start_i in cycle 0, no hold unless stated.
REQ-032 Read sequence: addresses SHALL be 0,4,8,1,5,9,... in cycles 1..24, 24 reads in total.
REQ-033 Window timing: core_en_o SHALL be high in cycles 11, 14, 23 and 26 only. Cycle-11 window bytes k0..k8 = 0,1,2,4,5,6,8,9,10 with ctr=(1,1). Cycle-26 window bytes = 5,6,7,9,10,11,13,14,15 with ctr=(2,2).
REQ-034 Frame end: done_o SHALL be high in cycle 27 only; busy_o SHALL be high in cycles 1..26 only; start_i pulsed in cycle 5 SHALL have no effect.
REQ-035 Hold: hold_i high in cycles 4..8 SHALL produce no reads in those cycles, no data loss, and every core_en_o delayed by exactly 5 cycles; with SOBEL_CTRL_PERF_EN defined, perf_hold_cnt_o=5.
REQ-036 Mid-frame reset: rst_n low in cycle 15 SHALL give all outputs 0 and IDLE; a restart SHALL reproduce REQ-032..REQ-034 exactly.

Source files
------------

// File: rtl/sobel_window_ctrl_if.sv
// rtl/sobel_window_ctrl_if.sv - memory read bus and window output bundle for sobel_window_ctrl
//
// Signals (directions as seen by the controller, modport master):
//   mem_rd_en_o  out  one-cycle read strobe
//   mem_addr_o   out  read address (AW bits), valid with mem_rd_en_o
//   mem_rdata_i  in   read data, valid one cycle after mem_rd_en_o
//   win_o        out  3x3 window, byte k=r*3+c at [8k+7:8k]
//   core_en_o    out  new-window strobe
//   ctr_x_o      out  window-centre column
//   ctr_y_o      out  window-centre row
// The slave modport is the memory / window-consumer side.
interface sobel_window_ctrl_if #(
    parameter int AW = 12
);
    logic          mem_rd_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [7:0]    mem_rdata_i;
    logic [71:0]   win_o;
    logic          core_en_o;
    logic [11:0]   ctr_x_o;
    logic [11:0]   ctr_y_o;

    modport master (
        output mem_rd_en_o, mem_addr_o, win_o, core_en_o, ctr_x_o, ctr_y_o,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_rd_en_o, mem_addr_o, win_o, core_en_o, ctr_x_o, ctr_y_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/sobel_window_ctrl.sv
// rtl/sobel_window_ctrl.sv - 3x3 sliding-window fetch controller for a Sobel core
//
// Walks a frame stored row-major in byte memory. For every centre row y and
// every column c it reads rows y-1, y, y+1 in three consecutive un-held
// cycles, assembles the column and shifts it into a 3x3 window; from the
// third column of a row onward each shift produces one window.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start_i          start a frame pass (sampled only in IDLE)
//   hold_i           freeze issue of new reads while high
//   busy_o           frame in progress
//   done_o           one-cycle end-of-frame pulse
//   perf_hold_cnt_o  (only with SOBEL_CTRL_PERF_EN) busy&hold cycle count,
//                    cleared on start, saturating
//   bus              sobel_window_ctrl_if.master: memory read + window output
//
// Optional feature macro: SOBEL_CTRL_PERF_EN
module sobel_window_ctrl #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int AW    = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 hold_i,
    output logic                 busy_o,
    output logic                 done_o,
`ifdef SOBEL_CTRL_PERF_EN
    output logic [31:0]          perf_hold_cnt_o,
`endif
    sobel_window_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // One row down in memory, and the step from the bottom read of one
    // column back to the top read of the next: -2*W + 1. The same step also
    // lands on column 0 of the next centre row after the last column.
    localparam logic [AW-1:0] ROW_STEP  = AW'(IMG_W);
    localparam logic [AW-1:0] COL_STEP  = AW'(1) - AW'(2 * IMG_W);
    localparam logic [11:0]   LAST_COL  = 12'(IMG_W - 1);
    localparam logic [11:0]   LAST_ROW  = 12'(IMG_H - 2);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    phase_q, phase_d;     // 0: row y-1, 1: row y, 2: row y+1
    logic [11:0]   col_q, col_d;
    logic [11:0]   row_q, row_d;         // current centre row

    // Attributes of the read in flight (data returns next cycle)
    logic          rd_vld_q, rd_vld_d;
    logic [1:0]    rd_phase_q, rd_phase_d;
    logic [11:0]   rd_col_q, rd_col_d;
    logic [11:0]   rd_row_q, rd_row_d;

    logic [7:0]    cb0_q, cb0_d;         // top byte of column being assembled
    logic [7:0]    cb1_q, cb1_d;         // middle byte
    logic [71:0]   win_q, win_d;
    logic          core_en_q, core_en_d;
    logic [11:0]   ctr_x_q, ctr_x_d;
    logic [11:0]   ctr_y_q, ctr_y_d;
    logic          done_q, done_d;

    logic          rd_en;

    // Hold must stop a read in the very cycle it is high, so the strobe is
    // decoded from registered state and the live hold input.
    assign rd_en = (state_q == ST_RUN) && !hold_i;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        phase_d    = phase_q;
        col_d      = col_q;
        row_d      = row_q;
        rd_vld_d   = rd_en;
        rd_phase_d = rd_phase_q;
        rd_col_d   = rd_col_q;
        rd_row_d   = rd_row_q;
        cb0_d      = cb0_q;
        cb1_d      = cb1_q;
        win_d      = win_q;
        core_en_d  = 1'b0;
        ctr_x_d    = ctr_x_q;
        ctr_y_d    = ctr_y_q;
        done_d     = 1'b0;

        if (rd_en) begin
            rd_phase_d = phase_q;
            rd_col_d   = col_q;
            rd_row_d   = row_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    addr_d  = '0;
                    phase_d = 2'd0;
                    col_d   = 12'd0;
                    row_d   = 12'd1;
                end
            end
            ST_RUN: begin
                if (rd_en) begin
                    if (phase_q != 2'd2) begin
                        addr_d  = addr_q + ROW_STEP;
                        phase_d = phase_q + 2'd1;
                    end else begin
                        addr_d  = addr_q + COL_STEP;
                        phase_d = 2'd0;
                        if (col_q == LAST_COL) begin
                            col_d = 12'd0;
                            if (row_q == LAST_ROW) begin
                                state_d = ST_FIN;
                            end else begin
                                row_d = row_q + 12'd1;
                            end
                        end else begin
                            col_d = col_q + 12'd1;
                        end
                    end
                end
            end
            ST_FIN: begin
                // Only the final column's window can still be pending here.
                if (core_en_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Capture is never gated by hold: an issued read always lands.
        if (rd_vld_q) begin
            case (rd_phase_q)
                2'd0:    cb0_d = bus.mem_rdata_i;
                2'd1:    cb1_d = bus.mem_rdata_i;
                default: begin
                    for (int r = 0; r < 3; r++) begin
                        win_d[r*24 +: 16] = win_q[r*24+8 +: 16];
                    end
                    win_d[23:16] = cb0_q;
                    win_d[47:40] = cb1_q;
                    win_d[71:64] = bus.mem_rdata_i;
                    // Column index restarts every row, so windows never
                    // straddle two rows.
                    if (rd_col_q >= 12'd2) begin
                        core_en_d = 1'b1;
                        ctr_x_d   = rd_col_q - 12'd1;
                        ctr_y_d   = rd_row_q;
                    end
                end
            endcase
        end
    end

`ifdef SOBEL_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == ST_IDLE) begin
            if (start_i) begin
                perf_d = 32'd0;
            end
        end else if (hold_i && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_hold_cnt_o = perf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            phase_q    <= 2'd0;
            col_q      <= 12'd0;
            row_q      <= 12'd0;
            rd_vld_q   <= 1'b0;
            rd_phase_q <= 2'd0;
            rd_col_q   <= 12'd0;
            rd_row_q   <= 12'd0;
            cb0_q      <= 8'd0;
            cb1_q      <= 8'd0;
            win_q      <= 72'd0;
            core_en_q  <= 1'b0;
            ctr_x_q    <= 12'd0;
            ctr_y_q    <= 12'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            phase_q    <= phase_d;
            col_q      <= col_d;
            row_q      <= row_d;
            rd_vld_q   <= rd_vld_d;
            rd_phase_q <= rd_phase_d;
            rd_col_q   <= rd_col_d;
            rd_row_q   <= rd_row_d;
            cb0_q      <= cb0_d;
            cb1_q      <= cb1_d;
            win_q      <= win_d;
            core_en_q  <= core_en_d;
            ctr_x_q    <= ctr_x_d;
            ctr_y_q    <= ctr_y_d;
            done_q     <= done_d;
        end
    end

    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = done_q;
    assign bus.mem_rd_en_o = rd_en;
    assign bus.mem_addr_o  = rd_en ? addr_q : '0;
    assign bus.win_o       = win_q;
    assign bus.core_en_o   = core_en_q;
    assign bus.ctr_x_o     = ctr_x_q;
    assign bus.ctr_y_o     = ctr_y_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb/tb_sobel_window_ctrl.sv - self-checking bench for sobel_window_ctrl
module tb_sobel_window_ctrl;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int AW   = 12;
    localparam int MAXC = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_i = 1'b0;
    logic hold_i = 1'b0;
    logic busy_o;
    logic done_o;
`ifdef SOBEL_CTRL_PERF_EN
    logic [31:0] perf_hold_cnt_o;
`endif

    sobel_window_ctrl_if #(.AW(AW)) bus ();

    sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .hold_i          (hold_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
`ifdef SOBEL_CTRL_PERF_EN
        .perf_hold_cnt_o (perf_hold_cnt_o),
`endif
        .bus             (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [W*H];

    always @(posedge clk) begin
        if (bus.mem_rd_en_o) bus.mem_rdata_i <= mem[bus.mem_addr_o[3:0]];
    end

    int n_chk = 0;
    int n_fail = 0;

    bit          hold_m   [MAXC];
    bit          exp_rd   [MAXC];
    int          exp_addr [MAXC];
    bit          exp_core [MAXC];
    logic [71:0] exp_win  [MAXC];
    int          exp_cx   [MAXC];
    int          exp_cy   [MAXC];
    bit          exp_busy [MAXC];
    bit          exp_done [MAXC];
    int          exp_last;
    int          exp_perf;

    task automatic chk(input string tag, input int r, input logic [71:0] obs, input logic [71:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, r, obs, exp);
        end
    endtask

    // Reference: walk centre rows / columns / the three rows in order, placing
    // each read on the next un-held cycle; a window appears two cycles after
    // the bottom read of column c>=2 and covers columns c-2..c.
    task automatic build_model();
        int t;
        for (int i = 0; i < MAXC; i++) begin
            exp_rd[i] = 0; exp_addr[i] = 0; exp_core[i] = 0; exp_win[i] = '0;
            exp_cx[i] = 0; exp_cy[i] = 0; exp_busy[i] = 0; exp_done[i] = 0;
        end
        t = 1;
        exp_last = 0;
        for (int y = 1; y <= H - 2; y++) begin
            for (int c = 0; c < W; c++) begin
                for (int dr = -1; dr <= 1; dr++) begin
                    while (hold_m[t]) t++;
                    exp_rd[t]   = 1;
                    exp_addr[t] = (y + dr) * W + c;
                    if (dr == 1 && c >= 2) begin
                        exp_core[t+2] = 1;
                        exp_cx[t+2]   = c - 1;
                        exp_cy[t+2]   = y;
                        for (int rr = 0; rr < 3; rr++)
                            for (int cc = 0; cc < 3; cc++)
                                exp_win[t+2][8*(rr*3+cc) +: 8] = mem[(y-1+rr)*W + (c-2+cc)];
                        exp_last = t + 2;
                    end
                    t++;
                end
            end
        end
        exp_perf = 0;
        for (int i = 1; i <= exp_last; i++) begin
            exp_busy[i] = 1;
            if (hold_m[i]) exp_perf++;
        end
        exp_done[exp_last+1] = 1;
    endtask

    task automatic chk_zero(input int r);
        chk("rst_rd_en", r, 72'(bus.mem_rd_en_o), 72'(0));
        chk("rst_addr",  r, 72'(bus.mem_addr_o),  72'(0));
        chk("rst_win",   r, bus.win_o,            72'(0));
        chk("rst_core",  r, 72'(bus.core_en_o),   72'(0));
        chk("rst_ctr_x", r, 72'(bus.ctr_x_o),     72'(0));
        chk("rst_ctr_y", r, 72'(bus.ctr_y_o),     72'(0));
        chk("rst_busy",  r, 72'(busy_o),          72'(0));
        chk("rst_done",  r, 72'(done_o),          72'(0));
`ifdef SOBEL_CTRL_PERF_EN
        chk("rst_perf",  r, 72'(perf_hold_cnt_o), 72'(0));
`endif
    endtask

    // Entered at posedge+#1; cycle 0 is the start cycle.
    task automatic run_frame(input int restart_at, input int rst_at, input int len);
        for (int r = 0; r < len; r++) begin
            start_i = (r == 0) || (r == restart_at);
            hold_i  = hold_m[r];
            rst_n   = (r != rst_at);
            @(negedge clk);
            if (r == rst_at) begin
                chk_zero(r);
            end else begin
                chk("rd_en", r, 72'(bus.mem_rd_en_o), 72'(exp_rd[r]));
                if (exp_rd[r]) chk("addr", r, 72'(bus.mem_addr_o), 72'(exp_addr[r]));
                chk("core_en", r, 72'(bus.core_en_o), 72'(exp_core[r]));
                if (exp_core[r]) begin
                    chk("win",   r, bus.win_o,            exp_win[r]);
                    chk("ctr_x", r, 72'(bus.ctr_x_o),     72'(exp_cx[r]));
                    chk("ctr_y", r, 72'(bus.ctr_y_o),     72'(exp_cy[r]));
                end
                chk("busy", r, 72'(busy_o), 72'(exp_busy[r]));
                chk("done", r, 72'(done_o), 72'(exp_done[r]));
            end
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        hold_i  = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic idle_check(input int n);
        for (int r = 0; r < n; r++) begin
            @(negedge clk);
            chk("idle_busy",  r, 72'(busy_o),           72'(0));
            chk("idle_rd_en", r, 72'(bus.mem_rd_en_o),  72'(0));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_hold();
        for (int i = 0; i < MAXC; i++) hold_m[i] = 0;
    endtask

    task automatic mem_identity();
        for (int a = 0; a < W*H; a++) mem[a] = 8'(a);
    endtask

    initial begin
        mem_identity();
        clear_hold();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero(0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain frame, with a stray start in cycle 5
        build_model();
        run_frame(5, -1, exp_last + 4);
`ifdef SOBEL_CTRL_PERF_EN
        chk("perf_nohold", 0, 72'(perf_hold_cnt_o), 72'(exp_perf));
`endif

        // Hold in cycles 4..8
        for (int i = 4; i <= 8; i++) hold_m[i] = 1;
        build_model();
        run_frame(-1, -1, exp_last + 4);
`ifdef SOBEL_CTRL_PERF_EN
        chk("perf_hold", 0, 72'(perf_hold_cnt_o), 72'(exp_perf));
`endif
        clear_hold();

        // Reset in cycle 15, stays idle, then a full restart
        build_model();
        run_frame(-1, 15, 16);
        idle_check(3);
        run_frame(5, -1, exp_last + 4);

        // Random image contents and random hold patterns, hold in cycle 0 too
        for (int f = 0; f < 6; f++) begin
            for (int a = 0; a < W*H; a++) mem[a] = 8'($urandom);
            clear_hold();
            for (int i = 0; i < 50; i++) hold_m[i] = ($urandom_range(0, 3) == 0);
            build_model();
            run_frame(-1, -1, exp_last + 4);
`ifdef SOBEL_CTRL_PERF_EN
            chk("perf_rand", f, 72'(perf_hold_cnt_o), 72'(exp_perf));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
